lsu_mem_initiator: RTL

- Core-side load/store initiator for the RV32I datapath. Drives a word-addressed, byte-enabled memory port with a request/grant handshake.
- Takes one load/store from the execute stage and converts the RV32I access into one or two aligned word transactions. A misaligned access that crosses a word boundary uses two transactions.
- Merges the returned data and sign- or zero-extends it, then returns a single result to the core.
- Memory-side counterpart to the data memory. The core stalls on `in_ready` low.

---
 rtl/lsu_mem_initiator.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one RV32I load/store from the core into one or
// two word-aligned, byte-enabled memory transactions with a req/gnt handshake,
// merges read beats and returns a single extended result.
module lsu_mem_initiator #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  is_load,
   input  logic [1:0]  is_store,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic        out_valid,
   output logic [31:0] rd_data,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_RESP0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_RESP1 = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   state_e      state_r, state_nxt_s;
   logic [31:0] addr_r, wr_data_r, rd_data_r;
   logic [31:0] buf0_r, buf1_r, buf0_nxt_s, buf1_nxt_s;
   logic [2:0]  load_r;
   logic [1:0]  store_r;
   logic [2:0]  size_s;
   logic [1:0]  off_s;
   logic        split_s;
   logic [7:0]  mask_s;
   logic [63:0] wdata64_s;
   logic [31:0] beat0_addr_s, beat1_addr_s;
   logic [31:0] merged_s, ext_s;

   // Access size in bytes (1, 2 or 4); 0 when no operation is requested.
   function automatic logic [2:0] size_f(input logic [2:0] ld, input logic [1:0] st);
      logic [2:0] n;
      n = 3'd0;
      case (ld)
         3'b001, 3'b101: n = 3'd1;
         3'b010, 3'b110: n = 3'd2;
         3'b011:         n = 3'd4;
         default: begin
            case (st)
               2'b01:   n = 3'd1;
               2'b10:   n = 3'd2;
               2'b11:   n = 3'd4;
               default: n = 3'd0;
            endcase
         end
      endcase
      return n;
   endfunction

   // An access crosses a word boundary when its last byte lands past lane 3.
   function automatic logic split_f(input logic [1:0] off, input logic [2:0] n);
      return (({1'b0, off} + n) > 3'd4);
   endfunction

   // Both load and store requested, or a reserved load encoding.
   function automatic logic illegal_f(input logic [2:0] ld, input logic [1:0] st);
      return ((ld != 3'b000) && (st != 2'b00)) || (ld == 3'b100) || (ld == 3'b111);
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Request latch, read-beat buffers and the held result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r    <= 32'h0;
         wr_data_r <= 32'h0;
         load_r    <= 3'b000;
         store_r   <= 2'b00;
         buf0_r    <= 32'h0;
         buf1_r    <= 32'h0;
         rd_data_r <= 32'h0;
      end else begin
         buf0_r <= buf0_nxt_s;
         buf1_r <= buf1_nxt_s;
         if ((state_r == ST_IDLE) && in_valid) begin
            addr_r    <= addr;
            wr_data_r <= wr_data;
            load_r    <= is_load;
            store_r   <= is_store;
         end
         if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
            rd_data_r <= ext_s;
         end
      end
   end

   // Next-state selection for the beat sequencing.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!in_valid) begin
               state_nxt_s = ST_IDLE;
            end else if (illegal_f(is_load, is_store)) begin
               state_nxt_s = ST_ERR;
            end else if ((is_load == 3'b000) && (is_store == 2'b00)) begin
               state_nxt_s = ST_IDLE;
            end else if (!ALLOW_MISALIGNED && split_f(addr[1:0], size_f(is_load, is_store))) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_REQ0;
            end
         end
         ST_REQ0: begin
            if (!mem_gnt) begin
               state_nxt_s = ST_REQ0;
            end else if (load_r != 3'b000) begin
               state_nxt_s = ST_RESP0;
            end else if (split_s) begin
               state_nxt_s = ST_REQ1;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_RESP0: begin
            if (!mem_rvalid) begin
               state_nxt_s = ST_RESP0;
            end else if (split_s) begin
               state_nxt_s = ST_REQ1;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_REQ1: begin
            if (!mem_gnt) begin
               state_nxt_s = ST_REQ1;
            end else if (load_r != 3'b000) begin
               state_nxt_s = ST_RESP1;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_RESP1: begin
            if (mem_rvalid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RESP1;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         ST_ERR:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Beat addresses, 8-lane byte mask and lane-shifted store data.
   always_comb begin
      size_s       = size_f(load_r, store_r);
      off_s        = addr_r[1:0];
      split_s      = split_f(off_s, size_s);
      beat0_addr_s = {addr_r[31:2], 2'b00};
      beat1_addr_s = beat0_addr_s + 32'd4;
      case (size_s)
         3'd1:    mask_s = 8'h01 << off_s;
         3'd2:    mask_s = 8'h03 << off_s;
         3'd4:    mask_s = 8'h0F << off_s;
         default: mask_s = 8'h00;
      endcase
      wdata64_s = {32'h0, wr_data_r} << {off_s, 3'b000};
   end

   // Read-beat capture; buffers are cleared when a new request is accepted.
   always_comb begin
      buf0_nxt_s = buf0_r;
      buf1_nxt_s = buf1_r;
      if ((state_r == ST_IDLE) && in_valid) begin
         buf0_nxt_s = 32'h0;
         buf1_nxt_s = 32'h0;
      end else if ((state_r == ST_RESP0) && mem_rvalid) begin
         buf0_nxt_s = mem_rdata;
      end else if ((state_r == ST_RESP1) && mem_rvalid) begin
         buf1_nxt_s = mem_rdata;
      end else begin
         buf0_nxt_s = buf0_r;
         buf1_nxt_s = buf1_r;
      end
   end

   // Align the two-word buffer to the byte offset and extend per load type.
   always_comb begin
      case (off_s)
         2'd0:    merged_s = buf0_nxt_s;
         2'd1:    merged_s = {buf1_nxt_s[7:0],  buf0_nxt_s[31:8]};
         2'd2:    merged_s = {buf1_nxt_s[15:0], buf0_nxt_s[31:16]};
         2'd3:    merged_s = {buf1_nxt_s[23:0], buf0_nxt_s[31:24]};
         default: merged_s = buf0_nxt_s;
      endcase
      case (load_r)
         3'b001:  ext_s = {{24{merged_s[7]}}, merged_s[7:0]};
         3'b101:  ext_s = {24'h0, merged_s[7:0]};
         3'b010:  ext_s = {{16{merged_s[15]}}, merged_s[15:0]};
         3'b110:  ext_s = {16'h0, merged_s[15:0]};
         3'b011:  ext_s = merged_s;
         default: ext_s = 32'h0;
      endcase
   end

   // Output decode from the registered state and latched request.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      err       = 1'b0;
      mem_req   = 1'b0;
      mem_we    = (store_r != 2'b00);
      mem_addr  = beat0_addr_s;
      mem_be    = mask_s[3:0];
      mem_wdata = wdata64_s[31:0];
      rd_data   = rd_data_r;
      case (state_r)
         ST_IDLE: in_ready  = 1'b1;
         ST_REQ0: mem_req   = 1'b1;
         ST_REQ1: begin
            mem_req   = 1'b1;
            mem_addr  = beat1_addr_s;
            mem_be    = mask_s[7:4];
            mem_wdata = wdata64_s[63:32];
         end
         ST_DONE: out_valid = 1'b1;
         ST_ERR:  err       = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

endmodule
